// File: rtl/tff_pkg.sv
// Shared definitions for the T flip-flop counter bank.
package tff_pkg;

  // Run-time operating modes of the counter bank.
  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  localparam int unsigned MAX_WIDTH = 32;

  // Largest legal modulus for a given register width.
  function automatic longint unsigned full_modulus(input int unsigned width);
    return 64'd1 << width;
  endfunction

endpackage

// File: rtl/tff_counter_param_if.sv
// Control/status bundle for tff_counter_param: the master drives the
// command side, the counter (slave) returns state, terminal count and wrap.
interface tff_counter_param_if
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) ();

  logic             en;
  mode_e            mode;
  logic [WIDTH-1:0] t_in;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output en, mode, t_in, d,
    input  q, tc, wrap
  );

  modport slave (
    input  en, mode, t_in, d,
    output q, tc, wrap
  );

endinterface

// File: rtl/tff_cell.sv
// Single T flip-flop with synchronous active-high reset.
module tff_cell (
  input  logic clk,
  input  logic reset_sync,
  input  logic t,
  output logic q
);

  logic q_q;
  logic q_d;

  // Toggle when t is high, otherwise hold.
  always_comb begin
    q_d = q_q ^ t;
  end

  // State register; reset wins over toggle.
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/tff_counter_param.sv
// WIDTH-bit toggle/up/down/load register built from T flip-flop cells.
// The next value is chosen by a mode mux and applied only through the
// per-bit T inputs (T = q ^ q_next); wrap is a registered one-cycle pulse.
module tff_counter_param
  import tff_pkg::*;
#(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic                clk,
  input  logic                reset_sync,
  tff_counter_param_if.slave  bus
);

  if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
    $error("tff_counter_param: WIDTH must be 1..%0d", MAX_WIDTH);
  end
  if ((MODULUS < 2) || (MODULUS > full_modulus(WIDTH))) begin : g_bad_modulus
    $error("tff_counter_param: MODULUS must be 2..2**WIDTH");
  end

  // Terminal value of the count sequence (MODULUS-1) at register width.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] t;
  logic             wrap_q;
  logic             wrap_d;

  // Next-state mux; an unknown mode falls to the default arm and holds.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.en) begin
      case (bus.mode)
        MODE_TOGGLE: q_d = q_q ^ bus.t_in;
        MODE_UP: begin
          if (q_q >= MAX_Q) begin
            q_d    = '0;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if ((q_q == '0) || (q_q > MAX_Q)) begin
            q_d    = MAX_Q;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q - WIDTH'(1);
          end
        end
        MODE_LOAD: q_d = bus.d;
        default: begin
          q_d    = q_q;
          wrap_d = 1'b0;
        end
      endcase
    end
  end

  // Per-bit toggle enables: only bits that must change get T=1.
  always_comb begin
    t = q_q ^ q_d;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk        (clk),
      .reset_sync (reset_sync),
      .t          (t[i]),
      .q          (q_q[i])
    );
  end

  // Wrap pulse register; reset clears it even on a wrapping edge.
  always_ff @(posedge clk) begin
    if (reset_sync) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  // Combinational terminal count and output drive.
  always_comb begin
    bus.tc   = bus.en & (((bus.mode == MODE_UP)   & (q_q >= MAX_Q)) |
                         ((bus.mode == MODE_DOWN) & (q_q == '0)));
    bus.q    = q_q;
    bus.wrap = wrap_q;
  end

  mode_known_a: assert property (@(posedge clk) disable iff (reset_sync)
    bus.en |-> !$isunknown(bus.mode))
    else $warning("tff_counter_param: mode is X/Z while enabled, holding q");

endmodule

// File: tb/tb_tff_counter_param.sv
// Bench for tff_counter_param: three instances (4-bit mod 16, 4-bit mod 10,
// 1-bit mod 2), directed scenarios plus random traffic against a model.
module tb_tff_counter_param;
  import tff_pkg::*;

  logic clk;
  logic rst_a, rst_b, rst_c;

  tff_counter_param_if #(.WIDTH(4)) if_a ();
  tff_counter_param_if #(.WIDTH(4)) if_b ();
  tff_counter_param_if #(.WIDTH(1)) if_c ();

  tff_counter_param #(.WIDTH(4), .MODULUS(16)) dut_a (
    .clk(clk), .reset_sync(rst_a), .bus(if_a.slave));
  tff_counter_param #(.WIDTH(4), .MODULUS(10)) dut_b (
    .clk(clk), .reset_sync(rst_b), .bus(if_b.slave));
  tff_counter_param #(.WIDTH(1), .MODULUS(2)) dut_c (
    .clk(clk), .reset_sync(rst_c), .bus(if_c.slave));

  int unsigned     widths [3] = '{4, 4, 1};
  longint unsigned mods   [3] = '{16, 10, 2};
  longint unsigned mq     [3] = '{0, 0, 0};
  bit              mw     [3] = '{0, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: next state straight from the mode rules, using plain integers.
  function automatic void ref_next(input longint unsigned q, input bit rst, input bit en,
                                   input int mode, input longint unsigned t,
                                   input longint unsigned d, input longint unsigned m,
                                   input int unsigned w, output longint unsigned qn,
                                   output bit wn, output bit tc);
    longint unsigned mask = (64'd1 << w) - 1;
    tc = en && (((mode == 1) && (q >= m - 1)) || ((mode == 2) && (q == 0)));
    qn = q;
    wn = 1'b0;
    if (rst) begin
      qn = 0;
    end else if (en) begin
      case (mode)
        0: qn = q ^ (t & mask);
        1: if (q >= m - 1) begin qn = 0; wn = 1'b1; end else qn = q + 1;
        2: if (q == 0 || q > m - 1) begin qn = m - 1; wn = 1'b1; end else qn = q - 1;
        default: qn = d & mask;
      endcase
    end
  endfunction

  function automatic longint unsigned get_q(input int k);
    case (k)
      0: return 64'(if_a.q);
      1: return 64'(if_b.q);
      default: return 64'(if_c.q);
    endcase
  endfunction

  function automatic bit get_wrap(input int k);
    case (k)
      0: return if_a.wrap;
      1: return if_b.wrap;
      default: return if_c.wrap;
    endcase
  endfunction

  function automatic bit get_tc(input int k);
    case (k)
      0: return if_a.tc;
      1: return if_b.tc;
      default: return if_c.tc;
    endcase
  endfunction

  task automatic drive(input int k, input bit rst, input bit en, input logic [1:0] mode,
                       input longint unsigned t, input longint unsigned d);
    case (k)
      0: begin rst_a = rst; if_a.en = en; if_a.mode = mode_e'(mode);
               if_a.t_in = 4'(t); if_a.d = 4'(d); end
      1: begin rst_b = rst; if_b.en = en; if_b.mode = mode_e'(mode);
               if_b.t_in = 4'(t); if_b.d = 4'(d); end
      default: begin rst_c = rst; if_c.en = en; if_c.mode = mode_e'(mode);
               if_c.t_in = 1'(t); if_c.d = 1'(d); end
    endcase
  endtask

  // One clock on instance k (others idle); returns observed and modelled tc.
  task automatic step(input int k, input bit rst, input bit en, input logic [1:0] mode,
                      input longint unsigned t, input longint unsigned d,
                      output bit tc_obs, output bit tc_exp);
    longint unsigned qn;
    bit wn;
    for (int j = 0; j < 3; j++) begin
      if (j == k) drive(j, rst, en, mode, t, d);
      else        drive(j, 1'b0, 1'b0, 2'b00, 0, 0);
    end
    ref_next(mq[k], rst, en, int'(mode), t, d, mods[k], widths[k], qn, wn, tc_exp);
    #1;
    tc_obs = get_tc(k);
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      if (j == k) begin mq[j] = qn; mw[j] = wn; end
      else mw[j] = 1'b0;
    end
  endtask

  task automatic test_reset();
    bit tco, tce;
    for (int k = 0; k < 3; k++) begin
      step(k, 1'b1, 1'b0, 2'b01, 0, 0, tco, tce);
      n_checks++;
      if (get_q(k) !== 64'd0) begin
        n_fail++; $display("FAIL reset_q[%0d] got=%0d exp=0", k, get_q(k));
      end
      n_checks++;
      if (get_wrap(k) !== 1'b0) begin
        n_fail++; $display("FAIL reset_wrap[%0d] got=%0d exp=0", k, get_wrap(k));
      end
    end
  endtask

  task automatic test_up_full();
    bit tco, tce;
    step(0, 1'b1, 1'b0, 2'b00, 0, 0, tco, tce);
    for (int i = 0; i < 17; i++) begin
      step(0, 1'b0, 1'b1, 2'b01, 0, 0, tco, tce);
      n_checks++;
      if (tco !== (i == 15)) begin
        n_fail++; $display("FAIL up16_tc step=%0d got=%0d exp=%0d", i, tco, (i == 15));
      end
      n_checks++;
      if (get_q(0) !== 64'((i + 1) % 16)) begin
        n_fail++; $display("FAIL up16_q step=%0d got=%0d exp=%0d", i, get_q(0), (i + 1) % 16);
      end
      n_checks++;
      if (get_wrap(0) !== (i == 15)) begin
        n_fail++; $display("FAIL up16_wrap step=%0d got=%0d exp=%0d", i, get_wrap(0), (i == 15));
      end
    end
  endtask

  task automatic test_load_wrap();
    bit tco, tce;
    step(1, 1'b0, 1'b1, 2'b11, 0, 12, tco, tce);
    n_checks++;
    if (get_q(1) !== 64'd12) begin n_fail++; $display("FAIL mod10_load got=%0d exp=12", get_q(1)); end
    step(1, 1'b0, 1'b1, 2'b01, 0, 0, tco, tce);
    n_checks++;
    if (tco !== 1'b1) begin n_fail++; $display("FAIL mod10_up_tc got=%0d exp=1", tco); end
    n_checks++;
    if (get_q(1) !== 64'd0 || get_wrap(1) !== 1'b1) begin
      n_fail++; $display("FAIL mod10_up_wrap got q=%0d w=%0d exp q=0 w=1", get_q(1), get_wrap(1));
    end
    step(1, 1'b0, 1'b1, 2'b10, 0, 0, tco, tce);
    n_checks++;
    if (tco !== 1'b1) begin n_fail++; $display("FAIL mod10_down_tc got=%0d exp=1", tco); end
    n_checks++;
    if (get_q(1) !== 64'd9 || get_wrap(1) !== 1'b1) begin
      n_fail++; $display("FAIL mod10_down_wrap got q=%0d w=%0d exp q=9 w=1", get_q(1), get_wrap(1));
    end
    step(1, 1'b0, 1'b1, 2'b11, 0, 14, tco, tce);
    step(1, 1'b0, 1'b1, 2'b10, 0, 0, tco, tce);
    n_checks++;
    if (tco !== 1'b0) begin n_fail++; $display("FAIL mod10_clamp_tc got=%0d exp=0", tco); end
    n_checks++;
    if (get_q(1) !== 64'd9 || get_wrap(1) !== 1'b1) begin
      n_fail++; $display("FAIL mod10_clamp got q=%0d w=%0d exp q=9 w=1", get_q(1), get_wrap(1));
    end
  endtask

  task automatic test_toggle();
    bit tco, tce;
    step(0, 1'b0, 1'b1, 2'b11, 0, 5, tco, tce);
    step(0, 1'b0, 1'b1, 2'b00, 3, 0, tco, tce);
    n_checks++;
    if (get_q(0) !== 64'd6 || get_wrap(0) !== 1'b0) begin
      n_fail++; $display("FAIL toggle_1 got q=%0d w=%0d exp q=6 w=0", get_q(0), get_wrap(0));
    end
    step(0, 1'b0, 1'b1, 2'b00, 3, 0, tco, tce);
    n_checks++;
    if (get_q(0) !== 64'd5 || get_wrap(0) !== 1'b0) begin
      n_fail++; $display("FAIL toggle_2 got q=%0d w=%0d exp q=5 w=0", get_q(0), get_wrap(0));
    end
  endtask

  task automatic test_enable_hold();
    bit tco, tce;
    step(0, 1'b0, 1'b1, 2'b11, 0, 7, tco, tce);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0, 1'b0, 2'b01, 0, 0, tco, tce);
      n_checks++;
      if (get_q(0) !== 64'd7 || tco !== 1'b0 || get_wrap(0) !== 1'b0) begin
        n_fail++;
        $display("FAIL hold step=%0d got q=%0d tc=%0d w=%0d exp q=7 tc=0 w=0",
                 i, get_q(0), tco, get_wrap(0));
      end
    end
    step(0, 1'b0, 1'b1, 2'b01, 0, 0, tco, tce);
    n_checks++;
    if (get_q(0) !== 64'd8) begin n_fail++; $display("FAIL hold_release got=%0d exp=8", get_q(0)); end
  endtask

  task automatic test_reset_override();
    bit tco, tce;
    step(1, 1'b0, 1'b1, 2'b11, 0, 9, tco, tce);
    step(1, 1'b1, 1'b1, 2'b01, 0, 0, tco, tce);
    n_checks++;
    if (get_q(1) !== 64'd0 || get_wrap(1) !== 1'b0) begin
      n_fail++; $display("FAIL rst_override got q=%0d w=%0d exp q=0 w=0", get_q(1), get_wrap(1));
    end
    step(1, 1'b0, 1'b1, 2'b01, 0, 0, tco, tce);
    n_checks++;
    if (get_q(1) !== 64'd1) begin n_fail++; $display("FAIL rst_resume got=%0d exp=1", get_q(1)); end
  endtask

  task automatic test_back_to_back();
    bit tco, tce;
    step(2, 1'b1, 1'b0, 2'b00, 0, 0, tco, tce);
    for (int i = 0; i < 4; i++) begin
      step(2, 1'b0, 1'b1, 2'b01, 0, 0, tco, tce);
      n_checks++;
      if (tco !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL w1_tc step=%0d got=%0d exp=%0d", i, tco, (i % 2 == 1));
      end
      n_checks++;
      if (get_q(2) !== 64'((i + 1) % 2) || get_wrap(2) !== (i % 2 == 1)) begin
        n_fail++;
        $display("FAIL w1_up step=%0d got q=%0d w=%0d exp q=%0d w=%0d",
                 i, get_q(2), get_wrap(2), (i + 1) % 2, (i % 2 == 1));
      end
    end
  endtask

  task automatic test_random();
    bit tco, tce;
    for (int i = 0; i < 400; i++) begin
      int k = $urandom_range(0, 2);
      bit rst = ($urandom_range(0, 24) == 0);
      bit en = ($urandom_range(0, 4) != 0);
      logic [1:0] mode = 2'($urandom_range(0, 3));
      longint unsigned t = 64'($urandom);
      longint unsigned d = 64'($urandom);
      if (mode == 2'b11 && $urandom_range(0, 1) == 1) mode = 2'($urandom_range(1, 2));
      step(k, rst, en, mode, t, d, tco, tce);
      n_checks++;
      if (tco !== tce) begin
        n_fail++; $display("FAIL rand_tc it=%0d dut=%0d got=%0d exp=%0d", i, k, tco, tce);
      end
      n_checks++;
      if (get_q(k) !== mq[k]) begin
        n_fail++; $display("FAIL rand_q it=%0d dut=%0d got=%0d exp=%0d", i, k, get_q(k), mq[k]);
      end
      n_checks++;
      if (get_wrap(k) !== mw[k]) begin
        n_fail++; $display("FAIL rand_wrap it=%0d dut=%0d got=%0d exp=%0d", i, k, get_wrap(k), mw[k]);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 3; j++) drive(j, 1'b1, 1'b0, 2'b00, 0, 0);
    @(posedge clk);
    #1;
    test_reset();
    test_up_full();
    test_load_wrap();
    test_toggle();
    test_enable_hold();
    test_reset_override();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
